trena_media: RTL and testbench
==============================

# trena_media

Parametrised ultrasonic distance-measurement core, successor to the single-shot trena datapath/controller pair. Drives the HC-SR04-style trigger, times the echo, and converts the echo width to centimetres. Averages 2^LOG2_SAMPLES samples per measurement and reports echo timeouts. It also has a built-in periodic auto mode with a programmable interval. Sits between the edge-detected `mensurar` pulse and the BCD/serial output stages.

## Interface
- TRIGGER_CYCLES, 500: trigger pulse width in clocks (10 µs @ 50 MHz).
- CYCLES_PER_CM, 2941: echo-high clocks per centimetre.
- DIST_WIDTH, 12: width of the distance result in cm.
- LOG2_SAMPLES, 2: log2 of the samples averaged per measurement (0 gives a single sample).
- GAP_CYCLES, 3000000: idle clocks between consecutive samples (60 ms).
- TIMEOUT_CYCLES, 1500000: maximum wait for echo rise, and maximum echo-high duration.
- AUTO_PERIOD_CYCLES, 25000000: interval between auto-mode starts.

- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- mensurar  in  1  one-cycle start pulse, already edge-detected.
- modo_auto  in  1  level; 1 enables periodic measurement.
- echo  in  1  asynchronous sensor echo; 2-FF synchronised internally (echo_s).
- trigger  out  1  sensor trigger pulse.
- distancia  out  DIST_WIDTH  last valid averaged distance in cm.
- pronto  out  1  one-cycle pulse at the end of every measurement (valid or timed out).
- erro  out  1  1 if the last measurement timed out; cleared by the next valid result.
- db_estado  out  4  current FSM state code.

## Operation
- FSM states and codes:
  - OCIOSO 0
  - PREPARA 1: clear accumulator and sample counter.
  - TRIGGER 2
  - ESPERA 3: wait for echo_s = 1.
  - MEDE 4
  - ACUMULA 5
  - INTERVALO 6
  - FINAL 7
  - ERRO 14
- OCIOSO → PREPARA on `mensurar`=1, or on auto expiry (see below).
- PREPARA → TRIGGER. `trigger`=1 for exactly TRIGGER_CYCLES cycles, then ESPERA.
- ESPERA: timeout counter starts at 0.
  - echo_s=1 → MEDE.
  - TIMEOUT_CYCLES cycles elapse first → ERRO.
- MEDE, each cycle with echo_s=1:
  - sub-counter increments; on reaching CYCLES_PER_CM-1 it wraps to 0 and the cm counter increments.
  - The cm counter saturates at 2^DIST_WIDTH-1.
  - Result: cm = floor(H/CYCLES_PER_CM), where H = synchronised echo-high cycles.
- MEDE exits:
  - echo_s=0 → ACUMULA.
  - H reaches TIMEOUT_CYCLES → ERRO.
- ACUMULA: acc += cm. acc is DIST_WIDTH+LOG2_SAMPLES bits wide and cannot overflow. Sample counter increments.
  - If 2^LOG2_SAMPLES samples are done → FINAL.
  - Otherwise → INTERVALO.
- INTERVALO: wait GAP_CYCLES, then → TRIGGER.
- FINAL: distancia ← acc >> LOG2_SAMPLES (truncating). erro ← 0. pronto=1. → OCIOSO.
- ERRO: distancia unchanged. erro ← 1. pronto=1. Remaining samples are abandoned. → OCIOSO.
- Auto mode:
  - The period counter runs only in OCIOSO with modo_auto=1. It clears on leaving OCIOSO and whenever modo_auto=0.
  - Reaching AUTO_PERIOD_CYCLES-1 starts a measurement.
  - `mensurar` in OCIOSO starts immediately regardless of mode.
- `mensurar` outside OCIOSO is ignored (not queued).
- modo_auto falling mid-measurement: the current measurement completes normally.
- Simultaneous `mensurar` and auto expiry: a single measurement starts.

## Timing
- Reset (synchronous, highest priority, valid mid-operation): state OCIOSO, trigger=0, distancia=0, pronto=0, erro=0, db_estado=0. All counters, accumulator and synchroniser cleared.
- `mensurar` at cycle t: PREPARA at t+1, trigger rises at t+2, trigger falls at t+2+TRIGGER_CYCLES.
- Echo path latency: 2 cycles through the synchroniser. The echo_s rise is seen in ESPERA; MEDE begins the following cycle and counts H from then on.
- Echo falling: ACUMULA on the cycle after echo_s=0 is seen in MEDE.
- Final sample: FINAL follows ACUMULA by one cycle. distancia updates and pronto pulses in the same cycle; both are registered outputs valid the cycle after FINAL.
- pronto is exactly one cycle high per measurement.
- trigger is registered and glitch-free.

## Test plan
Bench parameters: TRIGGER_CYCLES=4, CYCLES_PER_CM=10, LOG2_SAMPLES=2, GAP_CYCLES=8, TIMEOUT_CYCLES=200, AUTO_PERIOD_CYCLES=1000, DIST_WIDTH=8.

- Single measurement: `mensurar` pulse; 4 echoes of 123, 130, 145, 150 cycles → cm 12, 13, 14, 15; distancia=13, pronto one pulse, erro=0, trigger pulsed 4 times × 4 cycles, ≥8 cycles apart.
- Timeout: `mensurar`, no echo → pronto at ~206 cycles after start, erro=1, distancia holds previous 13. A subsequent valid measurement of 50-cycle echoes → distancia=5, erro=0.
- Long echo: echo held high 250 cycles → ERRO, erro=1; echo exactly 199 cycles → valid, cm=19.
- Saturation: with DIST_WIDTH=4, 4 echoes of 190 cycles → distancia=15.
- Auto mode: modo_auto=1, echoes of 60 cycles → pronto repeats with OCIOSO dwell of 1000 cycles, distancia=6. Drop modo_auto mid-sample → that measurement finishes, no further starts. `mensurar` during TRIGGER is ignored.
- Reset mid-MEDE → next cycle all outputs 0, db_estado=0; a fresh `mensurar` works normally.

Source files
------------

// File: rtl/trena_media_if.sv
// Signal bundle between the trena_media core and its surroundings:
// start/mode/echo inputs and the trigger, result and status outputs.
interface trena_media_if #(
  parameter int DIST_WIDTH = 12
);
  logic                  mensurar;
  logic                  modo_auto;
  logic                  echo;
  logic                  trigger;
  logic [DIST_WIDTH-1:0] distancia;
  logic                  pronto;
  logic                  erro;
  logic [3:0]            db_estado;

  // Environment side: issues starts, selects the mode, returns the echo.
  modport master (
    output mensurar, modo_auto, echo,
    input  trigger, distancia, pronto, erro, db_estado
  );

  // Core side.
  modport slave (
    input  mensurar, modo_auto, echo,
    output trigger, distancia, pronto, erro, db_estado
  );
endinterface

// File: rtl/trena_media.sv
// Ultrasonic distance core: fires the trigger, times the synchronised
// echo, converts the width to centimetres, averages 2^LOG2_SAMPLES
// samples, reports timeouts and can restart itself periodically.
module trena_media #(
  parameter int TRIGGER_CYCLES     = 500,
  parameter int CYCLES_PER_CM      = 2941,
  parameter int DIST_WIDTH         = 12,
  parameter int LOG2_SAMPLES       = 2,
  parameter int GAP_CYCLES         = 3000000,
  parameter int TIMEOUT_CYCLES     = 1500000,
  parameter int AUTO_PERIOD_CYCLES = 25000000
) (
  input logic          clock,
  input logic          reset,
  trena_media_if.slave bus
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam logic [3:0] OCIOSO    = 4'd0;
  localparam logic [3:0] PREPARA   = 4'd1;
  localparam logic [3:0] TRIGGER   = 4'd2;
  localparam logic [3:0] ESPERA    = 4'd3;
  localparam logic [3:0] MEDE      = 4'd4;
  localparam logic [3:0] ACUMULA   = 4'd5;
  localparam logic [3:0] INTERVALO = 4'd6;
  localparam logic [3:0] FINAL     = 4'd7;
  localparam logic [3:0] ERRO      = 4'd14;

  // One shared phase counter times trigger, echo wait, echo width and gap.
  localparam int CNT_MAX = max_of(max_of(TRIGGER_CYCLES, TIMEOUT_CYCLES), GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUB_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam int PER_W   = $clog2(AUTO_PERIOD_CYCLES + 1);
  localparam int ACC_W   = DIST_WIDTH + LOG2_SAMPLES;
  localparam int SMP_W   = LOG2_SAMPLES + 1;

  localparam logic [CNT_W-1:0]      TRIG_LAST = CNT_W'(TRIGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [PER_W-1:0]      PER_LAST  = PER_W'(AUTO_PERIOD_CYCLES - 1);
  localparam logic [SMP_W-1:0]      SMP_TOTAL = SMP_W'(1 << LOG2_SAMPLES);
  localparam logic [DIST_WIDTH-1:0] CM_MAX    = '1;

  logic [3:0]            state;
  logic [3:0]            state_next;
  logic                  echo_m;
  logic                  echo_s;
  logic [CNT_W-1:0]      cnt;
  logic [SUB_W-1:0]      sub;
  logic [DIST_WIDTH-1:0] cm;
  logic [PER_W-1:0]      period;
  logic [ACC_W-1:0]      acc;
  logic [SMP_W-1:0]      samples;
  logic [SMP_W-1:0]      samples_inc;
  logic                  auto_fire;
  logic                  trigger_q;
  logic [DIST_WIDTH-1:0] distancia_q;
  logic                  pronto_q;
  logic                  erro_q;

  assign samples_inc = samples + SMP_W'(1);
  assign auto_fire   = bus.modo_auto && (period == PER_LAST);

  // Next-state selection for the measurement sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      OCIOSO:    if (bus.mensurar || auto_fire) state_next = PREPARA;
      PREPARA:   state_next = TRIGGER;
      TRIGGER:   if (cnt == TRIG_LAST) state_next = ESPERA;
      ESPERA: begin
        if (echo_s)                 state_next = MEDE;
        else if (cnt == TOUT_LAST)  state_next = ERRO;
      end
      MEDE: begin
        if (!echo_s)                state_next = ACUMULA;
        else if (cnt == TOUT_LAST)  state_next = ERRO;
      end
      ACUMULA:   state_next = (samples_inc == SMP_TOTAL) ? FINAL : INTERVALO;
      INTERVALO: if (cnt == GAP_LAST) state_next = TRIGGER;
      FINAL:     state_next = OCIOSO;
      ERRO:      state_next = OCIOSO;
      default:   state_next = OCIOSO;
    endcase
  end

  // State, synchroniser, counters, accumulator and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, and all state uses non-blocking assignments
    // so every register samples values from before this edge.
    if (reset) begin
      state       <= OCIOSO;
      echo_m      <= 1'b0;
      echo_s      <= 1'b0;
      cnt         <= '0;
      sub         <= '0;
      cm          <= '0;
      period      <= '0;
      acc         <= '0;
      samples     <= '0;
      trigger_q   <= 1'b0;
      distancia_q <= '0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      echo_m    <= bus.echo;
      echo_s    <= echo_m;
      state     <= state_next;
      trigger_q <= (state_next == TRIGGER);
      pronto_q  <= 1'b0;

      // The ESPERA cycle that sees echo_s rise is the first echo-high cycle.
      if (state == ESPERA && state_next == MEDE)
        cnt <= CNT_W'(1);
      else if (state_next != state)
        cnt <= '0;
      else if (state inside {TRIGGER, ESPERA, MEDE, INTERVALO})
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;

      if (state == OCIOSO && state_next == OCIOSO && bus.modo_auto)
        period <= period + PER_W'(1);
      else
        period <= '0;

      if (state == ESPERA && state_next == MEDE) begin
        if (CYCLES_PER_CM == 1) begin
          sub <= '0;
          cm  <= DIST_WIDTH'(1);
        end else begin
          sub <= SUB_W'(1);
          cm  <= '0;
        end
      end else if (state == MEDE && echo_s) begin
        if (sub == SUB_LAST) begin
          sub <= '0;
          if (cm != CM_MAX) cm <= cm + DIST_WIDTH'(1);
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end

      if (state == PREPARA) begin
        acc     <= '0;
        samples <= '0;
      end else if (state == ACUMULA) begin
        acc     <= acc + ACC_W'(cm);
        samples <= samples_inc;
      end

      if (state == FINAL) begin
        distancia_q <= DIST_WIDTH'(acc >> LOG2_SAMPLES);
        erro_q      <= 1'b0;
        pronto_q    <= 1'b1;
      end else if (state == ERRO) begin
        erro_q   <= 1'b1;
        pronto_q <= 1'b1;
      end
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.distancia = distancia_q;
  assign bus.pronto    = pronto_q;
  assign bus.erro      = erro_q;
  assign bus.db_estado = state;

endmodule

// File: tb/tb_trena_media.sv
// Self-checking bench for trena_media: two instances (8-bit and 4-bit
// results) share stimulus; a sample-level model predicts each result.
module tb_trena_media;

  localparam int TRIG = 4;
  localparam int CPC  = 10;
  localparam int L2S  = 2;
  localparam int NS   = 1 << L2S;
  localparam int GAP  = 8;
  localparam int TOUT = 200;
  localparam int AUTO = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mensurar = 1'b0;
  logic modo_auto = 1'b0;
  logic echo = 1'b0;

  int checks = 0;
  int failures = 0;

  trena_media_if #(.DIST_WIDTH(8)) bus8 ();
  trena_media_if #(.DIST_WIDTH(4)) bus4 ();

  assign bus8.mensurar  = mensurar;
  assign bus8.modo_auto = modo_auto;
  assign bus8.echo      = echo;
  assign bus4.mensurar  = mensurar;
  assign bus4.modo_auto = modo_auto;
  assign bus4.echo      = echo;

  trena_media #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .DIST_WIDTH(8),
                .LOG2_SAMPLES(L2S), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT),
                .AUTO_PERIOD_CYCLES(AUTO))
    dut8 (.clock(clk), .reset(reset), .bus(bus8.slave));

  trena_media #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .DIST_WIDTH(4),
                .LOG2_SAMPLES(L2S), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT),
                .AUTO_PERIOD_CYCLES(AUTO))
    dut4 (.clock(clk), .reset(reset), .bus(bus4.slave));

  always #5 clk = ~clk;

  // Observation counters filled by the monitor.
  int cyc = 0;
  int pronto_cnt = 0, pronto_cyc = 0, pronto_long = 0;
  int trig_rises = 0, trig_bad = 0, trig_run = 0, trig_gap = 0, min_gap = 1 << 30;
  int prepara_cyc = 0;
  bit seen_fall = 0, prev_pronto = 0, prev_trig = 0;
  logic [3:0] prev_state = 4'd0;
  logic [7:0] d8_at;
  logic [3:0] d4_at;
  logic erro8_at, erro4_at, pronto4_at;

  // Model state: last valid averages and error flag.
  int lens[NS];
  int m_dist8 = 0, m_dist4 = 0, m_erro = 0, m_samples = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus8.pronto) begin
      pronto_cnt++;
      pronto_cyc = cyc;
      d8_at      = bus8.distancia;
      d4_at      = bus4.distancia;
      erro8_at   = bus8.erro;
      erro4_at   = bus4.erro;
      pronto4_at = bus4.pronto;
      if (prev_pronto) pronto_long++;
    end
    prev_pronto = bus8.pronto;
    if (bus8.trigger) begin
      if (!prev_trig) begin
        trig_rises++;
        if (seen_fall && trig_gap < min_gap) min_gap = trig_gap;
      end
      trig_run++;
    end else begin
      if (prev_trig) begin
        if (trig_run != TRIG) trig_bad++;
        trig_run  = 0;
        seen_fall = 1;
        trig_gap  = 0;
      end
      trig_gap++;
    end
    prev_trig = bus8.trigger;
    if (bus8.db_estado == 4'd1 && prev_state != 4'd1) prepara_cyc = cyc;
    prev_state = bus8.db_estado;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d);
    lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d;
  endtask

  // Sample-level model: each echo of H cycles is floor(H/CPC) cm, clamped to
  // the result range; a missing echo or H >= TOUT aborts with an error.
  task automatic run_model();
    int s8, s4, cmv;
    bit err;
    s8 = 0; s4 = 0; err = 0; m_samples = 0;
    for (int i = 0; i < NS; i++) begin
      m_samples++;
      if (lens[i] == 0 || lens[i] >= TOUT) begin
        err = 1;
        break;
      end
      cmv = lens[i] / CPC;
      s8 += (cmv > 255) ? 255 : cmv;
      s4 += (cmv > 15) ? 15 : cmv;
    end
    if (!err) begin
      m_dist8 = s8 / NS;
      m_dist4 = s4 / NS;
    end
    m_erro = err;
  endtask

  task automatic wait_trigger(output bit got);
    for (int n = 0; n < 3000 && bus8.trigger !== 1'b1; n++) tick();
    got = (bus8.trigger === 1'b1);
  endtask

  task automatic measure(input bit pulse, input bit drop_auto, input bit poke);
    int p0, t0, start, n;
    bit got, ended;
    p0 = pronto_cnt;
    t0 = trig_rises;
    start = 0;
    run_model();
    if (pulse) begin
      mensurar = 1'b1;
      tick();
      start = cyc;
      mensurar = 1'b0;
    end
    ended = 0;
    for (int i = 0; i < NS && !ended; i++) begin
      wait_trigger(got);
      check("trigger_seen", 32'(got), 32'd1);
      if (!got) return;
      n = 0;
      while (bus8.trigger === 1'b1 && n < 100) begin
        mensurar = (poke && i == 1 && n == 1);
        tick();
        n++;
      end
      mensurar = 1'b0;
      if (drop_auto && i == 0) modo_auto = 1'b0;
      repeat ($urandom_range(1, 10)) tick();
      if (lens[i] == 0) begin
        ended = 1;
      end else begin
        echo = 1'b1;
        repeat (lens[i]) tick();
        echo = 1'b0;
        if (lens[i] >= TOUT) ended = 1;
      end
    end
    for (int k = 0; k < 1000 && pronto_cnt == p0; k++) tick();
    got = (pronto_cnt != p0);
    check("pronto_seen", 32'(got), 32'd1);
    repeat (2) tick();
    check("pronto_count", 32'(pronto_cnt - p0), 32'd1);
    check("pronto4_same", 32'(pronto4_at), 32'd1);
    check("trigger_count", 32'(trig_rises - t0), 32'(m_samples));
    check("distancia8", 32'(d8_at), 32'(m_dist8));
    check("distancia4", 32'(d4_at), 32'(m_dist4));
    check("erro8", 32'(erro8_at), 32'(m_erro));
    check("erro4", 32'(erro4_at), 32'(m_erro));
    if (pulse && lens[0] == 0)
      check("timeout_latency", 32'(pronto_cyc - start), 32'(2 + TRIG + TOUT));
  endtask

  initial begin
    int prev_pronto_cyc, p0;
    bit got;

    repeat (3) tick();
    check("rst_trigger", 32'(bus8.trigger), 32'd0);
    check("rst_distancia", 32'(bus8.distancia), 32'd0);
    check("rst_pronto", 32'(bus8.pronto), 32'd0);
    check("rst_erro", 32'(bus8.erro), 32'd0);
    check("rst_estado", 32'(bus8.db_estado), 32'd0);
    check("rst_distancia4", 32'(bus4.distancia), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Single averaged measurement.
    set_lens(123, 130, 145, 150);
    measure(1, 0, 0);
    // No echo: timeout, distance held; then a valid run clears erro.
    set_lens(0, 0, 0, 0);
    measure(1, 0, 0);
    set_lens(50, 50, 50, 50);
    measure(1, 0, 0);
    // Echo too long, then the longest valid echo.
    set_lens(250, 250, 250, 250);
    measure(1, 0, 0);
    set_lens(199, 199, 199, 199);
    measure(1, 0, 0);
    // Saturation of the 4-bit result instance.
    set_lens(190, 190, 190, 190);
    measure(1, 0, 0);
    // mensurar during TRIGGER is ignored.
    set_lens(80, 85, 90, 95);
    measure(1, 0, 1);
    p0 = pronto_cnt;
    repeat (50) tick();
    check("no_queued_start", 32'(pronto_cnt - p0), 32'd0);
    check("idle_after_poke", 32'(bus8.db_estado), 32'd0);

    // Auto mode: periodic restarts with a fixed idle dwell.
    modo_auto = 1'b1;
    set_lens(60, 60, 60, 60);
    measure(0, 0, 0);
    prev_pronto_cyc = pronto_cyc;
    measure(0, 0, 0);
    check("auto_dwell", 32'(prepara_cyc - prev_pronto_cyc), 32'(AUTO));
    measure(0, 1, 0);
    p0 = pronto_cnt;
    repeat (1200) tick();
    check("auto_stopped", 32'(pronto_cnt - p0), 32'd0);
    check("auto_idle", 32'(bus8.db_estado), 32'd0);

    // Randomised echo widths, including misses and over-long echoes.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NS; i++)
        lens[i] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(5, 215));
      measure(1, 0, 0);
    end

    // Reset in the middle of an echo measurement.
    mensurar = 1'b1;
    tick();
    mensurar = 1'b0;
    wait_trigger(got);
    check("rst_trig_seen", 32'(got), 32'd1);
    for (int n = 0; n < 100 && bus8.trigger === 1'b1; n++) tick();
    repeat (3) tick();
    echo = 1'b1;
    repeat (30) tick();
    check("mid_mede", 32'(bus8.db_estado), 32'd4);
    reset = 1'b1;
    tick();
    check("midrst_trigger", 32'(bus8.trigger), 32'd0);
    check("midrst_distancia", 32'(bus8.distancia), 32'd0);
    check("midrst_pronto", 32'(bus8.pronto), 32'd0);
    check("midrst_erro", 32'(bus8.erro), 32'd0);
    check("midrst_estado", 32'(bus8.db_estado), 32'd0);
    reset = 1'b0;
    echo = 1'b0;
    m_dist8 = 0;
    m_dist4 = 0;
    m_erro = 0;
    repeat (5) tick();
    set_lens(70, 70, 70, 70);
    measure(1, 0, 0);

    check("trigger_widths", 32'(trig_bad), 32'd0);
    check("pronto_single", 32'(pronto_long), 32'd0);
    check("trigger_gap_ok", 32'(min_gap >= GAP), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
